// File: rtl/rsa_private_exponent_derive.sv
// RSA private exponent derivation: phi = (p-1)*(q-1) via shift-add multiply, then
// d = e^-1 mod phi using an external extended binary GCD engine.
module rsa_private_exponent_derive #(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [WORD_WIDTH/2-1:0] p,
  input  logic [WORD_WIDTH/2-1:0] q,
  input  logic [WORD_WIDTH-1:0] e,
  output logic                  done,
  output logic                  err,
  output logic [WORD_WIDTH-1:0] phi,
  output logic [WORD_WIDTH-1:0] d,
  output logic                  gcd_enable,
  output logic [WORD_WIDTH-1:0] gcd_x,
  output logic [WORD_WIDTH-1:0] gcd_y,
  input  logic                  gcd_done,
  input  logic [WORD_WIDTH-1:0] gcd_result,
  input  logic [WORD_WIDTH-1:0] gcd_coeff_i
);

  localparam int unsigned HW    = WORD_WIDTH / 2;
  localparam int unsigned CNT_W = $clog2(HW + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(HW - 1);

  typedef enum logic [2:0] {IDLE, MUL, CHK, GCD_RUN, NORM, DONE} state_t;
  state_t state;

  logic [WORD_WIDTH-1:0] mcand, acc, acc_next, e_reg, coeff_reg, gcd_res_reg;
  logic [HW-1:0]         mplier;
  logic [CNT_W-1:0]      cnt;
  logic                  pq_bad, first_cycle;
  logic signed [WORD_WIDTH:0] c_ext, c_adj, c_norm, phi_ext;

  always_comb begin
    acc_next = mplier[0] ? acc + mcand : acc;
    c_ext    = $signed({coeff_reg[WORD_WIDTH-1], coeff_reg});
    phi_ext  = $signed({1'b0, phi});
    c_adj    = c_ext;
    if (c_ext < 0) c_adj = c_ext + phi_ext;
    c_norm = c_adj;
    if (c_adj >= phi_ext) c_norm = c_adj - phi_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      done        <= 1'b0;
      err         <= 1'b0;
      gcd_enable  <= 1'b0;
      phi         <= '0;
      d           <= '0;
      gcd_x       <= '0;
      gcd_y       <= '0;
      mcand       <= '0;
      acc         <= '0;
      mplier      <= '0;
      cnt         <= '0;
      e_reg       <= '0;
      coeff_reg   <= '0;
      gcd_res_reg <= '0;
      pq_bad      <= 1'b0;
      first_cycle <= 1'b0;
    end else if (!enable && state != IDLE && state != DONE) begin
      // request withdrawn mid-derivation: abandon without publishing a result
      state      <= IDLE;
      gcd_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: if (enable) begin
          mcand  <= {{HW{1'b0}}, p - 1'b1};
          mplier <= q - 1'b1;
          acc    <= '0;
          cnt    <= '0;
          e_reg  <= e;
          pq_bad <= (p < HW'(2)) || (q < HW'(2));
          state  <= MUL;
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            phi   <= acc_next;
            state <= CHK;
          end
        end
        CHK: begin
          if (pq_bad || e_reg == '0 || e_reg >= phi) begin
            err   <= 1'b1;
            d     <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            gcd_x       <= e_reg;
            gcd_y       <= phi;
            gcd_enable  <= 1'b1;
            first_cycle <= 1'b1;
            state       <= GCD_RUN;
          end
        end
        GCD_RUN: begin
          first_cycle <= 1'b0;
          // a done level left over from the engine's previous job is not ours
          if (!first_cycle && gcd_done) begin
            gcd_res_reg <= gcd_result;
            coeff_reg   <= gcd_coeff_i;
            gcd_enable  <= 1'b0;
            state       <= NORM;
          end
        end
        NORM: begin
          if (gcd_res_reg != WORD_WIDTH'(1)) begin
            err <= 1'b1;
            d   <= '0;
          end else begin
            err <= 1'b0;
            d   <= c_norm[WORD_WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: if (!enable) begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
